fp_accumulator: RTL and testbench

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

---
 rtl/fp_accumulator_pkg.sv | 30 +++
 rtl/fp_accumulator_fpaddsub.sv | 121 ++++++++++++
 rtl/fp_accumulator.sv | 126 ++++++++++++
 tb/tb_fp_accumulator.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_accumulator_pkg.sv
// +----------------------------------------------------------------------+
// | fp_accumulator_pkg : shared types and field-mask helpers             |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package fp_accumulator_pkg;

  localparam int MAX_W = 128;

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [MAX_W-1:0] FP_POS_ZERO = '0;

  // Exponent field set to all ones, positioned for a 2**log_bit-bit word.
  function automatic logic [MAX_W-1:0] fp_exp_mask(input int log_bit, input int exp_bit);
    return (~({MAX_W{1'b1}} << exp_bit)) << ((1 << log_bit) - 1 - exp_bit);
  endfunction

  // Mantissa field mask; a word ANDed with this is nonzero iff the mantissa is nonzero.
  function automatic logic [MAX_W-1:0] fp_man_mask(input int log_bit, input int exp_bit);
    return ~({MAX_W{1'b1}} << ((1 << log_bit) - 1 - exp_bit));
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_accumulator_fpaddsub.sv
// +----------------------------------------------------------------------+
// | fp_accumulator_fpaddsub : combinational IEEE-754 add/sub, RNE        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_accumulator_fpaddsub
  import fp_accumulator_pkg::*;
#(
  parameter int LOG_BIT = 6,
  parameter int EXP_BIT = 11,
  localparam int W = 2**LOG_BIT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         addnot_sub,  // 1: a - b, 0: a + b
  output logic [W-1:0] y
);

  localparam int MW = W - 1 - EXP_BIT;
  localparam int GW = MW + 4;        // hidden + mantissa + guard/round/sticky
  localparam int SW = GW + 1;
  localparam int XW = EXP_BIT + 2;
  localparam logic [W-1:0] EXP_MASK = W'(fp_exp_mask(LOG_BIT, EXP_BIT));
  localparam logic [W-1:0] QUIET    = W'(1) << (MW - 1);
  localparam logic [W-1:0] QNAN     = EXP_MASK | QUIET;
  localparam logic [EXP_BIT-1:0] EXP_MAX = '1;

  logic               a_sign, b_sign, a_nan, b_nan, a_inf, b_inf;
  logic [EXP_BIT-1:0] a_exp, b_exp, x_exp, y_exp, e_field;
  logic [MW-1:0]      a_man, b_man, x_man, y_man;
  logic               swap, x_sign, y_sign, eff_sub, inc;
  logic [XW-1:0]      x_eexp, y_eexp, d, lead, lz, e;
  logic [GW-1:0]      x_sig, y_ext, y_al, norm;
  logic [SW-1:0]      sum;
  logic [W-2:0]       mag;

  assign a_sign = a[W-1];
  assign a_exp  = a[W-2:MW];
  assign a_man  = a[MW-1:0];
  assign b_sign = b[W-1] ^ addnot_sub;
  assign b_exp  = b[W-2:MW];
  assign b_man  = b[MW-1:0];
  assign a_nan  = (a_exp == EXP_MAX) && (a_man != '0);
  assign b_nan  = (b_exp == EXP_MAX) && (b_man != '0);
  assign a_inf  = (a_exp == EXP_MAX) && (a_man == '0);
  assign b_inf  = (b_exp == EXP_MAX) && (b_man == '0);
  assign swap   = {b_exp, b_man} > {a_exp, a_man};

  always_comb begin
    x_sign = swap ? b_sign : a_sign;
    y_sign = swap ? a_sign : b_sign;
    x_exp  = swap ? b_exp  : a_exp;
    y_exp  = swap ? a_exp  : b_exp;
    x_man  = swap ? b_man  : a_man;
    y_man  = swap ? a_man  : b_man;

    // Denormals share the effective exponent 1 with the smallest normals.
    x_eexp = (x_exp == '0) ? XW'(1) : XW'(x_exp);
    y_eexp = (y_exp == '0) ? XW'(1) : XW'(y_exp);
    x_sig  = {(x_exp != '0), x_man, 3'b000};
    y_ext  = {(y_exp != '0), y_man, 3'b000};
    d      = x_eexp - y_eexp;

    y_al = '0;
    if (d >= XW'(GW)) begin
      y_al[0] = |y_ext;
    end else begin
      y_al    = y_ext >> d;
      y_al[0] = y_al[0] | (|(y_ext & ~({GW{1'b1}} << d)));
    end

    eff_sub = x_sign ^ y_sign;
    sum = eff_sub ? ({1'b0, x_sig} - {1'b0, y_al}) : ({1'b0, x_sig} + {1'b0, y_al});

    lead = '0;
    for (int i = 0; i < SW; i++) begin
      if (sum[i]) lead = XW'(i);
    end
    lz = XW'(GW - 1) - lead;

    // Left shifts stop at effective exponent 1; the hidden bit then stays 0 (denormal).
    norm = '0;
    e    = '0;
    if (sum[SW-1]) begin
      norm = sum[SW-1:1] | {{(GW-1){1'b0}}, sum[0]};
      e    = x_eexp + XW'(1);
    end else if (lz < x_eexp) begin
      norm = sum[GW-1:0] << lz;
      e    = x_eexp - lz;
    end else begin
      norm = sum[GW-1:0] << (x_eexp - XW'(1));
      e    = XW'(1);
    end

    e_field = norm[GW-1] ? e[EXP_BIT-1:0] : '0;
    inc     = norm[2] & (norm[1] | norm[0] | norm[3]);
    mag     = {e_field, norm[GW-2:3]} + {{(W-2){1'b0}}, inc};

    if (a_nan) begin
      y = a | QUIET;
    end else if (b_nan) begin
      y = b | QUIET;
    end else if (a_inf && b_inf && (a_sign != b_sign)) begin
      y = QNAN;
    end else if (a_inf) begin
      y = a;
    end else if (b_inf) begin
      y = {b_sign, EXP_MAX, {MW{1'b0}}};
    end else if (sum == '0) begin
      y = {(eff_sub ? 1'b0 : x_sign), {(W-1){1'b0}}};
    end else if (e >= XW'(EXP_MAX)) begin
      y = {x_sign, EXP_MAX, {MW{1'b0}}};
    end else begin
      y = {x_sign, mag};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_accumulator.sv
// +----------------------------------------------------------------------+
// | fp_accumulator : streaming FP sum, one operand/cycle, held result    |
// | Optional FP_ACCUM_STICKY_FLAGS_EN adds out_nan/out_inf. Rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_accumulator
  import fp_accumulator_pkg::*;
#(
  parameter int LOG_BIT = 6,
  parameter int EXP_BIT = 11,
  parameter int CNT_BIT = 16,
  localparam int W = 2**LOG_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic               in_sub,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_data,
  output logic [CNT_BIT-1:0] out_count
`ifdef FP_ACCUM_STICKY_FLAGS_EN
  ,
  output logic               out_nan,
  output logic               out_inf
`endif
);

  localparam logic [W-1:0] ACC_ZERO = W'(FP_POS_ZERO);

  state_t             state_q, state_d;
  logic [W-1:0]       acc_q, acc_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [W-1:0]       sum;

  fp_accumulator_fpaddsub #(
    .LOG_BIT (LOG_BIT),
    .EXP_BIT (EXP_BIT)
  ) u_fpaddsub (
    .a          (acc_q),
    .b          (in_data),
    .addnot_sub (in_sub),
    .y          (sum)
  );

`ifdef FP_ACCUM_STICKY_FLAGS_EN
  localparam logic [W-1:0] EXP_MASK = W'(fp_exp_mask(LOG_BIT, EXP_BIT));
  localparam logic [W-1:0] MAN_MASK = W'(fp_man_mask(LOG_BIT, EXP_BIT));

  logic nan_q, nan_d, inf_q, inf_d, sum_nan, sum_inf;

  assign sum_nan = ((sum & EXP_MASK) == EXP_MASK) && ((sum & MAN_MASK) != '0);
  assign sum_inf = ((sum & EXP_MASK) == EXP_MASK) && ((sum & MAN_MASK) == '0);
  assign out_nan = nan_q;
  assign out_inf = inf_q;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef FP_ACCUM_STICKY_FLAGS_EN
    nan_d     = nan_q;
    inf_d     = inf_q;
`endif
    case (state_q)
      ST_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = sum;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_BIT'(1);
`ifdef FP_ACCUM_STICKY_FLAGS_EN
          nan_d = nan_q | sum_nan;
          inf_d = inf_q | sum_inf;
`endif
          if (in_last) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_d   = ACC_ZERO;
          cnt_d   = '0;
          state_d = ST_ACCUM;
`ifdef FP_ACCUM_STICKY_FLAGS_EN
          nan_d   = 1'b0;
          inf_d   = 1'b0;
`endif
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      acc_q   <= ACC_ZERO;
      cnt_q   <= '0;
`ifdef FP_ACCUM_STICKY_FLAGS_EN
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef FP_ACCUM_STICKY_FLAGS_EN
      nan_q   <= nan_d;
      inf_q   <= inf_d;
`endif
    end
  end

  assign out_data  = acc_q;
  assign out_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_accumulator.sv
// +----------------------------------------------------------------------+
// | tb_fp_accumulator : directed self-checking bench for fp_accumulator  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fp_accumulator;

  localparam logic [63:0] P0   = 64'h0000000000000000;
  localparam logic [63:0] P1   = 64'h3FF0000000000000;
  localparam logic [63:0] P2   = 64'h4000000000000000;
  localparam logic [63:0] P3   = 64'h4008000000000000;
  localparam logic [63:0] P5   = 64'h4014000000000000;
  localparam logic [63:0] P6   = 64'h4018000000000000;
  localparam logic [63:0] N1   = 64'hBFF0000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] NINF = 64'hFFF0000000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sub = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [63:0] out_data;
  logic [15:0] out_count;

  logic        s_in_valid = 1'b0, s_in_last = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [63:0] s_out_data;
  logic [1:0]  s_out_count;

`ifdef FP_ACCUM_STICKY_FLAGS_EN
  logic out_nan, out_inf, s_out_nan, s_out_inf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sub    (in_sub),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
`ifdef FP_ACCUM_STICKY_FLAGS_EN
    ,
    .out_nan   (out_nan),
    .out_inf   (out_inf)
`endif
  );

  fp_accumulator #(.CNT_BIT(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (P0),
    .in_sub    (1'b0),
    .in_last   (s_in_last),
    .out_valid (s_out_valid),
    .out_ready (1'b1),
    .out_data  (s_out_data),
    .out_count (s_out_count)
`ifdef FP_ACCUM_STICKY_FLAGS_EN
    ,
    .out_nan   (s_out_nan),
    .out_inf   (s_out_inf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic sub, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = sub;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_sub   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_handoff_valid", {63'd0, out_valid}, 64'd0);
    check("post_handoff_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    check("reset_ready", {63'd0, in_ready}, 64'd1);
    check("reset_data", out_data, P0);
    check("reset_count", {48'd0, out_count}, 64'd0);

    // 1 + 2 + 3 with idle cycles between operands
    send(P1, 1'b0, 1'b0);
    tick();
    tick();
    check("idle_hold_data", out_data, P1);
    check("idle_hold_count", {48'd0, out_count}, 64'd1);
    send(P2, 1'b0, 1'b0);
    send(P3, 1'b0, 1'b1);
    check("sum6_valid", {63'd0, out_valid}, 64'd1);
    check("sum6_ready", {63'd0, in_ready}, 64'd0);
    check("sum6_data", out_data, P6);
    check("sum6_count", {48'd0, out_count}, 64'd3);
    handoff();

    // 5 - 2
    send(P5, 1'b0, 1'b0);
    send(P2, 1'b1, 1'b1);
    check("sub3_data", out_data, P3);
    check("sub3_count", {48'd0, out_count}, 64'd2);
    handoff();

    // inf + (-inf)
    send(PINF, 1'b0, 1'b0);
    send(NINF, 1'b0, 1'b1);
    check("inf_nan_exp", {53'd0, out_data[62:52]}, 64'h7FF);
    check("inf_nan_man_nz", {63'd0, (out_data[51:0] != 52'd0)}, 64'd1);
`ifdef FP_ACCUM_STICKY_FLAGS_EN
    check("flag_nan", {63'd0, out_nan}, 64'd1);
    check("flag_inf", {63'd0, out_inf}, 64'd1);
`endif
    handoff();
`ifdef FP_ACCUM_STICKY_FLAGS_EN
    check("flag_nan_clr", {63'd0, out_nan}, 64'd0);
    check("flag_inf_clr", {63'd0, out_inf}, 64'd0);
`endif

    // single subtract from +0.0 gives -in_data
    send(P1, 1'b1, 1'b1);
    check("neg1_data", out_data, N1);
    check("neg1_count", {48'd0, out_count}, 64'd1);
    handoff();

    // 1.0 + 1.5*2^-53 rounds up; 1.0 + 2^-53 is a tie that rounds to even
    send(P1, 1'b0, 1'b0);
    send(64'h3CA8000000000000, 1'b0, 1'b1);
    check("round_up", out_data, 64'h3FF0000000000001);
    handoff();
    send(P1, 1'b0, 1'b0);
    send(64'h3CA0000000000000, 1'b0, 1'b1);
    check("round_tie_even", out_data, P1);
    handoff();

    // pending result with upstream still presenting an operand
    send(P1, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = P2;
    in_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready", {63'd0, in_ready}, 64'd0);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_data", out_data, P1);
      check("stall_count", {48'd0, out_count}, 64'd1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_release_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stall_next_data", out_data, P2);
    check("stall_next_count", {48'd0, out_count}, 64'd1);
    handoff();

    // reset aborts a partial sum
    send(P1, 1'b0, 1'b0);
    send(P2, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_ready", {63'd0, in_ready}, 64'd1);
    check("abort_count", {48'd0, out_count}, 64'd0);
    send(64'h0000000000000001, 1'b0, 1'b1);
    check("denorm_data", out_data, 64'h0000000000000001);
    check("denorm_count", {48'd0, out_count}, 64'd1);

    // reset also drops a pending result
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_hold_valid", {63'd0, out_valid}, 64'd0);
    check("abort_hold_data", out_data, P0);

    // counter saturation on the 2-bit instance
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_in_last = (i == 4);
      tick();
    end
    s_in_valid = 1'b0;
    s_in_last  = 1'b0;
    check("sat_valid", {63'd0, s_out_valid}, 64'd1);
    check("sat_count", {62'd0, s_out_count}, 64'd3);
    check("sat_data", s_out_data, P0);
    tick();
    check("sat_clear_count", {62'd0, s_out_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
